// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline sequencing
// controller. The optional exception/ERET path is built only when
// PIPE_CTRL_EXC_EN is defined.
package pipe_ctrl_pkg;

    // Controller state: normal running, or the one-cycle guard after an
    // exception has been taken.
    typedef enum logic {
        RUN       = 1'b0,
        EXC_ENTRY = 1'b1
    } state_t;

    // PC source select encodings driven on pc_sel.
    localparam logic [1:0] PC_SEL_SEQ = 2'd0;  // sequential / branch target
    localparam logic [1:0] PC_SEL_EXC = 2'd1;  // exception vector
    localparam logic [1:0] PC_SEL_EPC = 2'd2;  // return address from CP0 EPC

    // Address the fetch unit jumps to when pc_sel == PC_SEL_EXC.
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    // Default MDU latencies, in busy cycles after the start.
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_busy_cnt.sv
// md_busy_cnt: multiply/divide busy window counter. A qualified start loads
// the operation latency; the counter then counts down to zero and holds there.
module md_busy_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_go,
    input  logic is_div,
    output logic md_busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Load on a start (a start while busy simply reloads), else count down to zero.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples its inputs from before the edge, independent of block order.
        if (reset) begin
            cnt <= '0;
        end else if (md_go) begin
            cnt <= is_div ? DIV_LOAD : MULT_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign md_busy = (cnt != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage MIPS core.
// Drives the pipeline register enables and clears, the PC source select and
// the qualified MDU start. Define PIPE_CTRL_EXC_EN to build the exception /
// ERET handling; without it the controller only stalls and tracks the MDU.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_hazard,
    input  logic       d_md_use,
    input  logic       e_md_start,
    input  logic       e_md_div,
    input  logic       m_exc_req,
    input  logic       m_eret,
    output logic       f_we,
    output logic       d_we,
    output logic       e_we,
    output logic       m_we,
    output logic       d_clr,
    output logic       e_clr,
    output logic       m_clr,
    output logic       w_clr,
    output logic [1:0] pc_sel,
    output logic       md_go,
    output logic       md_busy
);

    logic exc_take;   // exception accepted this cycle
    logic eret_take;  // eret accepted this cycle (no competing exception)
    logic busy_raw;   // counter non-zero, before the reset override
    logic stall;

`ifdef PIPE_CTRL_EXC_EN
    state_t state;

    // Exceptions and erets are only honoured in RUN; EXC_ENTRY masks them.
    assign exc_take  = m_exc_req & (state == RUN);
    assign eret_take = m_eret & ~m_exc_req & (state == RUN);

    // Enter the guard state on an accepted exception; it always lasts one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= exc_take ? EXC_ENTRY : RUN;
        end
    end
`else
    // Without exception support the FSM collapses to a constant RUN and the
    // M-stage requests have no effect.
    logic unused_exc;
    assign unused_exc = m_exc_req ^ m_eret;
    assign exc_take   = 1'b0;
    assign eret_take  = 1'b0;
`endif

    // An MDU op in D must wait while the MDU is busy or is being started in E.
    assign stall = d_hazard | (d_md_use & (busy_raw | e_md_start));

    // A start coinciding with an accepted exception belongs to a flushed
    // instruction and is dropped; nothing starts while reset is held.
    assign md_go   = ~reset & e_md_start & ~exc_take;
    assign md_busy = ~reset & busy_raw;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_cnt (
        .clk     (clk),
        .reset   (reset),
        .md_go   (md_go),
        .is_div  (e_md_div),
        .md_busy (busy_raw)
    );

    // Pipeline register control: reset > exception > eret > stall > default.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // priority chain leaves one unassigned, which would infer a latch.
        f_we   = 1'b1;
        d_we   = 1'b1;
        e_we   = 1'b1;
        m_we   = 1'b1;
        d_clr  = 1'b0;
        e_clr  = 1'b0;
        m_clr  = 1'b0;
        w_clr  = 1'b0;
        pc_sel = PC_SEL_SEQ;
        if (!reset) begin
            if (exc_take) begin
                // Flush everything, including M/W, so the faulting op never commits.
                d_clr  = 1'b1;
                e_clr  = 1'b1;
                m_clr  = 1'b1;
                w_clr  = 1'b1;
                pc_sel = PC_SEL_EXC;
            end else if (eret_take) begin
                // The eret itself retires into M/W; younger ops are squashed.
                d_clr  = 1'b1;
                e_clr  = 1'b1;
                m_clr  = 1'b1;
                pc_sel = PC_SEL_EPC;
            end else if (stall) begin
                // Hold F/D and the PC, inject a bubble into D/E.
                f_we  = 1'b0;
                d_we  = 1'b0;
                e_clr = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl. Works for both builds;
// expectations that depend on exception support follow PIPE_CTRL_EXC_EN.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    // Input vector bits: {reset, d_hazard, d_md_use, e_md_start, e_md_div, m_exc_req, m_eret}
    localparam logic [6:0] I_IDLE = 7'b000_0000;
    localparam logic [6:0] I_RST  = 7'b100_0000;
    localparam logic [6:0] I_HAZ  = 7'b010_0000;
    localparam logic [6:0] I_USE  = 7'b001_0000;
    localparam logic [6:0] I_MUL  = 7'b000_1000;
    localparam logic [6:0] I_DIV  = 7'b000_1100;
    localparam logic [6:0] I_EXC  = 7'b000_0010;
    localparam logic [6:0] I_ERET = 7'b000_0001;

    // Output vector bits: {f_we,d_we,e_we,m_we, d_clr,e_clr,m_clr,w_clr, pc_sel[1:0], md_go, md_busy}
    localparam logic [11:0] O_DEF   = 12'b1111_0000_00_0_0;
    localparam logic [11:0] O_STALL = 12'b0011_0100_00_0_0;
    localparam logic [11:0] O_EXC   = 12'b1111_1111_01_0_0;
    localparam logic [11:0] O_ERET  = 12'b1111_1110_10_0_0;
    localparam logic [11:0] GO      = 12'b0000_0000_00_1_0;
    localparam logic [11:0] BUSY    = 12'b0000_0000_00_0_1;

    logic       clk = 1'b0;
    logic       reset, d_hazard, d_md_use, e_md_start, e_md_div, m_exc_req, m_eret;
    logic       f_we, d_we, e_we, m_we, d_clr, e_clr, m_clr, w_clr, md_go, md_busy;
    logic [1:0] pc_sel;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic [6:0]  in;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .d_hazard   (d_hazard),
        .d_md_use   (d_md_use),
        .e_md_start (e_md_start),
        .e_md_div   (e_md_div),
        .m_exc_req  (m_exc_req),
        .m_eret     (m_eret),
        .f_we       (f_we),
        .d_we       (d_we),
        .e_we       (e_we),
        .m_we       (m_we),
        .d_clr      (d_clr),
        .e_clr      (e_clr),
        .m_clr      (m_clr),
        .w_clr      (w_clr),
        .pc_sel     (pc_sel),
        .md_go      (md_go),
        .md_busy    (md_busy)
    );

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (we,clr,pc_sel,md_go,md_busy)", name, act, exp);
        end
    endtask

    // One cycle: drive inputs after the edge, queue the expectation, compare
    // at the falling edge, then advance past the next rising edge.
    task automatic step(input logic [6:0] in, input logic [11:0] exp, input string name);
        logic [11:0] e;
        string       n;
        {reset, d_hazard, d_md_use, e_md_start, e_md_div, m_exc_req, m_eret} = in;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, {f_we, d_we, e_we, m_we, d_clr, e_clr, m_clr, w_clr, pc_sel, md_go, md_busy}, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        {reset, d_hazard, d_md_use, e_md_start, e_md_div, m_exc_req, m_eret} = I_RST;
        @(posedge clk);
        #1;

        // Single-cycle behaviour, applied back to back from a clean reset.
        vecs[0]  = '{I_RST | I_HAZ | I_USE | I_DIV | I_EXC, O_DEF, "reset_forces_defaults"};
        vecs[1]  = '{I_RST | I_ERET | I_MUL, O_DEF, "reset_forces_defaults_2"};
        vecs[2]  = '{I_IDLE, O_DEF, "idle_default"};
        vecs[3]  = '{I_HAZ, O_STALL, "hazard_cycle1"};
        vecs[4]  = '{I_HAZ, O_STALL, "hazard_cycle2"};
        vecs[5]  = '{I_IDLE, O_DEF, "hazard_release"};
        vecs[6]  = '{I_USE, O_DEF, "md_use_idle_mdu"};
        vecs[7]  = '{I_ERET | I_HAZ, EXC_EN ? O_ERET : O_STALL, "eret_over_stall"};
        vecs[8]  = '{I_ERET, EXC_EN ? O_ERET : O_DEF, "eret_alone"};
        vecs[9]  = '{I_EXC | I_HAZ, EXC_EN ? O_EXC : O_STALL, "exc_over_stall"};
        vecs[10] = '{I_EXC | I_HAZ, O_STALL, "exc_entry_ignores_exc"};
        vecs[11] = '{I_EXC | I_ERET, EXC_EN ? O_EXC : O_DEF, "exc_over_eret"};
        vecs[12] = '{I_ERET, O_DEF, "exc_entry_ignores_eret"};
        vecs[13] = '{I_MUL | I_EXC, EXC_EN ? O_EXC : (O_DEF | GO), "start_with_exc"};
        vecs[14] = '{I_IDLE, EXC_EN ? O_DEF : (O_DEF | BUSY), "busy_after_start_exc"};
        vecs[15] = '{I_RST, O_DEF, "reset_clears_busy"};
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].in, vecs[i].exp, vecs[i].name);
        end

        // Divide with a dependent MDU op held in D: busy cycles 1..10, issue at 11.
        step(I_DIV | I_USE, O_STALL | GO, "div_start_stall");
        for (int i = 1; i <= 10; i++) begin
            step(I_USE, O_STALL | BUSY, $sformatf("div_busy_stall_c%0d", i));
        end
        step(I_USE, O_DEF, "div_release_c11");
        step(I_IDLE, O_DEF, "div_idle_after");

        // Multiply, dependent op arrives the next cycle: 5 stall cycles.
        step(I_MUL, O_DEF | GO, "mult_start");
        for (int i = 1; i <= 5; i++) begin
            step(I_USE, O_STALL | BUSY, $sformatf("mult_busy_stall_c%0d", i));
        end
        step(I_USE, O_DEF, "mult_release");

        // Exception during a running multiply does not stop the counter.
        step(I_MUL, O_DEF | GO, "mult_start_2");
        step(I_EXC, (EXC_EN ? O_EXC : O_DEF) | BUSY, "exc_mid_mult");
        for (int i = 2; i <= 5; i++) begin
            step(I_IDLE, O_DEF | BUSY, $sformatf("mult_continues_c%0d", i));
        end
        step(I_IDLE, O_DEF, "mult_done_after_exc");

        // A start while busy reloads the counter with the new latency.
        step(I_MUL, O_DEF | GO, "reload_mult_start");
        step(I_IDLE, O_DEF | BUSY, "reload_mult_busy");
        step(I_DIV, O_DEF | GO | BUSY, "reload_div_start");
        for (int i = 3; i <= 12; i++) begin
            step(I_IDLE, O_DEF | BUSY, $sformatf("reload_busy_c%0d", i));
        end
        step(I_IDLE, O_DEF, "reload_done");

        // Reset asserted at cycle 3 of a divide.
        step(I_DIV, O_DEF | GO, "div_start_rst");
        step(I_IDLE, O_DEF | BUSY, "div_rst_c1");
        step(I_IDLE, O_DEF | BUSY, "div_rst_c2");
        step(I_RST | I_USE, O_DEF, "div_rst_c3_forced");
        step(I_USE, O_DEF, "div_rst_after_edge");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It drives the write-enable and synchronous-clear lines of the F/D, D/E, E/M and M/W pipeline registers, and the PC source select. Inputs are the D-stage data-hazard stall, the multiply/divide unit (MDU) busy window, and exception/ERET requests raised at the M stage. The block owns the MDU busy counter and the one-cycle exception-entry guard state.

## Interface
Parameters:
- MULT_CYCLES, 5: busy cycles after a mult/multu start.
- DIV_CYCLES, 10: busy cycles after a div/divu start.
- CNT_W, 4: busy-counter width; must hold DIV_CYCLES.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- d_hazard  in  1  D-stage operand hazard (load-use / unforwardable).
- d_md_use  in  1  D-stage instruction is an MDU op (mult/div/mfhi/mflo/mthi/mtlo).
- e_md_start  in  1  E-stage mult/div issuing this cycle.
- e_md_div  in  1  with e_md_start: 1 selects div, 0 selects mult.
- m_exc_req  in  1  CP0 reports an interrupt or exception at M.
- m_eret  in  1  eret is in M.
- f_we, d_we, e_we, m_we  out  1  enables for F/D, D/E, E/M, M/W.
- d_clr, e_clr, m_clr, w_clr  out  1  synchronous clears for the same registers.
- pc_sel  out  2  0 = sequential/branch, 1 = exception vector 0x4180, 2 = EPC.
- md_go  out  1  qualified MDU start to the MDU.
- md_busy  out  1  busy counter non-zero.

## Operation
- Registered state: fsm ∈ {RUN, EXC_ENTRY}, busy counter cnt[CNT_W-1:0]. All control outputs are combinational from the registered state and the current inputs.
- Default (RUN, no event): all *_we = 1, all *_clr = 0, pc_sel = 0.
- Stall condition: stall = d_hazard | (d_md_use & (md_busy | e_md_start)). When stall is set: f_we = 0, d_we = 0, e_clr = 1 (bubble into D/E). E/M and M/W advance.
- ERET (m_eret, no exception): pc_sel = 2. d_clr, e_clr and m_clr are 1. M/W captures the eret. Stall is overridden.
- Exception (m_exc_req in RUN): pc_sel = 1. d_clr, e_clr, m_clr and w_clr are 1, so the faulting instruction does not commit. All we = 1. The FSM moves to EXC_ENTRY.
- EXC_ENTRY lasts exactly one cycle. In this state m_exc_req and m_eret are ignored, the stall logic acts normally, and the FSM returns to RUN.
- Priority: reset > exception > eret > stall > default.
- md_go = e_md_start & ~(m_exc_req & fsm==RUN). A start in the same cycle as an accepted exception is cancelled.
- Counter:
  - On md_go, cnt loads DIV_CYCLES or MULT_CYCLES.
  - Otherwise, cnt decrements while non-zero and saturates at 0.
  - md_busy = (cnt != 0).
  - md_go while md_busy reloads the counter. This cannot occur legally, because D stalls MDU ops.
- An exception does not clear an already-running counter; the MDU completes its operation.

## Timing
- Reset values: fsm = RUN, cnt = 0. While reset is high, outputs are forced to the defaults: all we = 1, all clr = 0, pc_sel = 0, md_go = 0, md_busy = 0.
- Stall, flush and pc_sel act in the same cycle as their cause, with zero latency. The pipeline registers react at the next clk edge.
- md_busy rises the cycle after md_go and stays high for exactly MULT_CYCLES or DIV_CYCLES cycles.
- A dependent MDU op in D issues on the first cycle md_busy is 0.
- Reset asserted mid-busy or in EXC_ENTRY: state and counter return to reset values at the next edge.

## Configuration
- PIPE_CTRL_EXC_EN defined: exception and ERET handling as above, including EXC_ENTRY.
- PIPE_CTRL_EXC_EN undefined:
  - m_exc_req and m_eret are ignored.
  - The FSM is a constant RUN.
  - pc_sel is constant 0 and w_clr is constant 0.
  - md_go = e_md_start.
  - Stall and MDU behaviour are unchanged.

## Structure
- pipe_ctrl_pkg contains:
  - the state enum (RUN, EXC_ENTRY);
  - PC_SEL_SEQ / PC_SEL_EXC / PC_SEL_EPC encodings;
  - the EXC_VECTOR = 32'h0000_4180 constant;
  - default MULT_CYCLES and DIV_CYCLES.
- One sub-module, md_busy_cnt: load/decrement counter with md_go, is_div and md_busy ports.

## Test plan
- d_hazard = 1 for 2 cycles -> f_we = d_we = 0 and e_clr = 1 in both cycles; defaults return on the 3rd cycle.
- e_md_start = 1, e_md_div = 1 at cycle 0, d_md_use held -> md_busy high in cycles 1–10; stall through cycle 10; d_we = 1 at cycle 11.
- mult start, then d_md_use in the next cycle -> stall for 5 cycles; release when cnt reaches 0.
- m_exc_req in RUN with d_hazard = 1 -> pc_sel = 1 and all 4 clr = 1 in that cycle; next cycle fsm = EXC_ENTRY and a repeated m_exc_req is ignored (pc_sel = 0).
- m_eret with d_hazard = 1 -> pc_sel = 2, d/e/m_clr = 1, w_clr = 0, f_we = 1.
- e_md_start together with m_exc_req -> md_go = 0 and md_busy stays 0; separately, reset at cycle 3 of a div -> md_busy = 0 after the edge.
